// File: rtl/serial_addsub_if.sv
// Start/ack handshake and result bundle for serial_addsub.
// Master drives the operands and en; the slave (the adder) returns the result and status.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;
  logic             busy;
  logic             done;

  modport master (
    output en, sub, a, b,
    input  out, cout, ovf, busy, done
  );

  modport slave (
    input  en, sub, a, b,
    output out, cout, ovf, busy, done
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial add/subtract, DIGIT bits per cycle; done rises WIDTH/DIGIT edges after the start.
// No backpressure: en starts in IDLE, en acknowledges in DONE; operands are captured once.
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic            clk,
  input logic            rst,
  serial_addsub_if.slave bus
);
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] out_reg;
  logic             carry;
  logic             cout_reg;
  logic             ovf_reg;
  logic [CW-1:0]    count;
  logic [DIGIT:0]   s;
  logic             c_msb;
  logic             last;

  // Carry into the digit's top bit is recovered from its sum bit and the two operand bits.
  always_comb begin
    s     = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    c_msb = s[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];
    last  = (count == CW'(NDIG - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.en) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (bus.en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg    <= '0;
      b_reg    <= '0;
      out_reg  <= '0;
      carry    <= 1'b0;
      count    <= '0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.en) begin
            a_reg    <= bus.a;
            b_reg    <= bus.sub ? ~bus.b : bus.b;
            carry    <= bus.sub;
            out_reg  <= '0;
            count    <= '0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
          end
        end
        RUN: begin
          // Sum digits enter at the MSB end so the result is aligned after NDIG shifts.
          out_reg <= (out_reg >> DIGIT) | (WIDTH'(s[DIGIT-1:0]) << (WIDTH - DIGIT));
          a_reg   <= a_reg >> DIGIT;
          b_reg   <= b_reg >> DIGIT;
          carry   <= s[DIGIT];
          count   <= count + CW'(1);
          if (last) begin
            cout_reg <= s[DIGIT];
            ovf_reg  <= c_msb ^ s[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out  = out_reg;
  assign bus.cout = cout_reg;
  assign bus.ovf  = ovf_reg;
  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub at (8,1), (8,2) and (16,4) with a scoreboard of expected results.
module tb_serial_addsub;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  serial_addsub_if #(.WIDTH(8))  if0 ();
  serial_addsub_if #(.WIDTH(8))  if1 ();
  serial_addsub_if #(.WIDTH(16)) if2 ();

  serial_addsub #(.WIDTH(8),  .DIGIT(1)) u0 (.clk(clk), .rst(rst), .bus(if0));
  serial_addsub #(.WIDTH(8),  .DIGIT(2)) u1 (.clk(clk), .rst(rst), .bus(if1));
  serial_addsub #(.WIDTH(16), .DIGIT(4)) u2 (.clk(clk), .rst(rst), .bus(if2));

  logic        en_t   [3];
  logic        sub_t  [3];
  logic [15:0] a_t    [3];
  logic [15:0] b_t    [3];
  logic [15:0] out_t  [3];
  logic        cout_t [3];
  logic        ovf_t  [3];
  logic        busy_t [3];
  logic        done_t [3];

  assign if0.en = en_t[0]; assign if0.sub = sub_t[0];
  assign if0.a  = a_t[0][7:0]; assign if0.b = b_t[0][7:0];
  assign if1.en = en_t[1]; assign if1.sub = sub_t[1];
  assign if1.a  = a_t[1][7:0]; assign if1.b = b_t[1][7:0];
  assign if2.en = en_t[2]; assign if2.sub = sub_t[2];
  assign if2.a  = a_t[2]; assign if2.b = b_t[2];

  assign out_t[0] = {8'h00, if0.out}; assign cout_t[0] = if0.cout; assign ovf_t[0] = if0.ovf;
  assign busy_t[0] = if0.busy; assign done_t[0] = if0.done;
  assign out_t[1] = {8'h00, if1.out}; assign cout_t[1] = if1.cout; assign ovf_t[1] = if1.ovf;
  assign busy_t[1] = if1.busy; assign done_t[1] = if1.done;
  assign out_t[2] = if2.out; assign cout_t[2] = if2.cout; assign ovf_t[2] = if2.ovf;
  assign busy_t[2] = if2.busy; assign done_t[2] = if2.done;

  typedef struct packed {
    logic [15:0] out;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int u);
    return (u == 2) ? 16 : 8;
  endfunction

  function automatic int ndig_of(input int u);
    return (u == 0) ? 8 : 4;
  endfunction

  // Reference: true integer add/subtract with signed range test for overflow.
  function automatic exp_t model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                 input logic sv);
    exp_t   e;
    longint m, half, ua, ub, sa, sb, r;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(av) & m;
    ub   = longint'(bv) & m;
    sa   = (ua >= half) ? ua - 2 * half : ua;
    sb   = (ub >= half) ? ub - 2 * half : ub;
    if (sv) begin
      e.out  = 16'((ua - ub) & m);
      e.cout = (ua >= ub);
      r      = sa - sb;
    end else begin
      e.out  = 16'((ua + ub) & m);
      e.cout = 1'(((ua + ub) >> w) & 1);
      r      = sa + sb;
    end
    e.ovf = (r >= half) || (r < -half);
    return e;
  endfunction

  // Called and returns at a negedge; the start is accepted at the next posedge.
  task automatic run_op(input int u, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic use_model, input logic [15:0] eo,
                        input logic ec, input logic eov, input int dwell,
                        input logic hold_en, input logic keep_en);
    exp_t e;
    int   lat;
    int   nb;
    logic [15:0] held_out;
    logic held_c, held_v;
    if (use_model) e = model(width_of(u), av, bv, sv);
    else e = {eo, ec, eov};
    sb_q.push_back(e);
    a_t[u] = av; b_t[u] = bv; sub_t[u] = sv; en_t[u] = 1'b1;
    @(negedge clk);
    lat = 0;
    nb  = 0;
    while (!done_t[u] && lat < 200) begin
      if (busy_t[u]) nb++;
      en_t[u]  = hold_en;
      a_t[u]   = 16'($urandom);
      b_t[u]   = 16'($urandom);
      sub_t[u] = 1'($urandom);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, ndig_of(u));
    chk("busy_cycles", nb, ndig_of(u));
    chk("busy_in_done", busy_t[u], 0);
    e = sb_q.pop_front();
    chk("out", out_t[u], e.out);
    chk("cout", cout_t[u], e.cout);
    chk("ovf", ovf_t[u], e.ovf);
    held_out = out_t[u]; held_c = cout_t[u]; held_v = ovf_t[u];
    for (int i = 0; i < dwell; i++) begin
      en_t[u] = 1'b0;
      a_t[u]  = 16'($urandom);
      b_t[u]  = 16'($urandom);
      @(negedge clk);
    end
    if (dwell > 0) begin
      chk("done_hold", {done_t[u], out_t[u], cout_t[u], ovf_t[u]},
          {1'b1, held_out, held_c, held_v});
    end
    en_t[u] = 1'b1;
    @(negedge clk);
    chk("ack_idle", {busy_t[u], done_t[u]}, 0);
    en_t[u] = keep_en;
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      en_t[u] = 1'b0; sub_t[u] = 1'b0; a_t[u] = '0; b_t[u] = '0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      chk("reset_state", {busy_t[u], done_t[u], out_t[u], cout_t[u], ovf_t[u]}, 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Idle with en low ignores operand activity.
    for (int i = 0; i < 20; i++) begin
      a_t[0] = 16'($urandom); b_t[0] = 16'($urandom); sub_t[0] = 1'($urandom);
      @(negedge clk);
      chk("idle_stable", {busy_t[0], done_t[0], out_t[0]}, 0);
    end

    run_op(0, 16'd100,  16'd27,   1'b0, 1'b0, 16'h007F, 1'b0, 1'b0, 10, 1'b0, 1'b0);
    run_op(0, 16'd100,  16'd28,   1'b0, 1'b0, 16'h0080, 1'b0, 1'b1, 1, 1'b0, 1'b0);
    run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 1'b0, 1'b0);
    run_op(1, 16'd5,    16'd7,    1'b1, 1'b0, 16'h00FE, 1'b0, 1'b0, 2, 1'b0, 1'b0);
    run_op(1, 16'h0080, 16'h0001, 1'b1, 1'b0, 16'h007F, 1'b1, 1'b1, 2, 1'b0, 1'b0);
    // en held high through RUN and the ack; the new operands start straight from IDLE.
    run_op(2, 16'h1234, 16'hEDCC, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b1, 1'b1);
    run_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1, 1'b0, 1'b0);

    // Reset aborts a run in progress.
    a_t[0] = 16'h00AA; b_t[0] = 16'h0055; sub_t[0] = 1'b0; en_t[0] = 1'b1;
    @(negedge clk);
    en_t[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("partial_out", {busy_t[0], out_t[0]}, {1'b1, 16'h00E0});
    rst = 1'b1;
    @(negedge clk);
    chk("reset_abort", {busy_t[0], done_t[0], out_t[0]}, 0);
    rst = 1'b0;
    run_op(0, 16'd1, 16'd2, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 5; k++) begin
        run_op(u, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1, 16'h0, 1'b0, 1'b0,
               1, 1'b0, 1'b0);
      end
    end
    // Corner operands: most negative value against +1 and itself.
    run_op(2, 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    run_op(1, 16'h0000, 16'h0080, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    run_op(0, 16'h0080, 16'h0080, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1, 1'b0, 1'b0);

    chk("sb_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised digit-serial adder/subtractor. Next generation of the team's 8-bit bit-serial adder.
- Processes DIGIT bits per clock over a WIDTH-bit operand pair.
- Adds subtract mode, carry-out and signed-overflow flags, and busy/done status.
- Used wherever area matters more than latency, e.g. accumulators in slow control paths. Sits behind a simple start/ack handshake.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 2 and a multiple of DIGIT.
- DIGIT, 1, bits processed per RUN cycle. Legal values 1..WIDTH, and WIDTH % DIGIT == 0.
- NDIG is derived, not overridable: NDIG = WIDTH/DIGIT, the number of RUN cycles.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  start request in IDLE; acknowledge in DONE.
- sub  input  1  0 = a+b, 1 = a−b. Sampled with en in IDLE.
- a  input  WIDTH  operand A. Sampled with en in IDLE.
- b  input  WIDTH  operand B. Sampled with en in IDLE.
- out  output  WIDTH  result, valid while done=1.
- cout  output  1  final carry out of the MSB. For subtract, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high while state is RUN.
- done  output  1  high while state is DONE.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE; out, a_reg, b_reg, carry, count, cout and ovf all 0; busy=0, done=0. Reset wins over every other input and aborts a RUN in progress. No partial result survives.
- States: IDLE, RUN, DONE, encoded 2'd0, 2'd1, 2'd2. Encoding 2'd3 is illegal and returns to IDLE on the next edge.
- IDLE with en=1:
  - a_reg←a.
  - b_reg←(sub ? ~b : b).
  - carry←sub.
  - out←0, count←0, cout←0, ovf←0.
  - state←RUN.
- IDLE with en=0: hold all state.
- RUN, every edge:
  - Take s = a_reg[DIGIT-1:0] + b_reg[DIGIT-1:0] + carry, computed (DIGIT+1) bits wide.
  - out←{s[DIGIT-1:0], out[WIDTH-1:DIGIT]}, i.e. the sum digit shifts in at the MSB end.
  - a_reg and b_reg shift right by DIGIT.
  - carry←s[DIGIT].
  - count←count+1. count is $clog2(NDIG+1) bits wide.
  - en and sub are ignored in RUN.
- Last RUN cycle (count==NDIG-1):
  - state←DONE.
  - cout←s[DIGIT].
  - ovf←(carry into bit WIDTH-1) XOR s[DIGIT]. The carry into bit WIDTH-1 is the internal carry at digit bit position DIGIT-1, computed combinationally inside the last digit.
- Latency: done rises exactly NDIG edges after the edge that accepted en. With WIDTH=8: DIGIT=1 gives 8 edges, DIGIT=4 gives 2, DIGIT=8 gives 1.
- DONE:
  - out, cout and ovf hold stable.
  - en=1 → IDLE. This is an acknowledge only; it does not start a new operation, so a new start needs en high again in IDLE.
  - en=0 → stay in DONE.
- Width rules:
  - Result is modulo 2^WIDTH.
  - Subtract is implemented as a + ~b + 1, with the +1 supplied through the initial carry.
  - No sign extension anywhere.
- Outputs busy and done are decoded directly from the state register (registered, glitch-free). out is itself a register.
- Operand inputs a/b may change freely after the accepting edge; they are not re-sampled.

Test Plan:
- WIDTH=8, DIGIT=1, sub=0, a=100, b=27, en pulsed one cycle → done after 8 edges; out=127, cout=0, ovf=0; busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=1, sub=0, a=100, b=28 → out=0x80, cout=0, ovf=1. Then a=0xFF, b=0x01 → out=0x00, cout=1, ovf=0.
- WIDTH=8, DIGIT=2, sub=1, a=5, b=7 → done after 4 edges; out=0xFE, cout=0, ovf=0. Then a=0x80, b=0x01 → out=0x7F, cout=1, ovf=1.
- WIDTH=16, DIGIT=4, sub=0, a=0x1234, b=0xEDCC → done after 4 edges; out=0x0000, cout=1, ovf=0. Holding en=1 through RUN has no effect; en=1 in DONE → IDLE; a further en=1 in IDLE starts a new operation.
- Reset mid-operation: WIDTH=8, DIGIT=1, start a=0xAA, b=0x55, assert rst after 3 RUN edges → next edge state=IDLE, out=0, busy=0, done=0. A subsequent start with a=1, b=2 gives out=3.
- Idle stability: en=0 for 20 cycles with random a/b/sub → state stays IDLE and out stays 0. In DONE with en=0 for 10 cycles, out, cout and ovf stay unchanged.
